// File: rtl/inst_fetch_resp.sv
// Instruction fetch with a 2-deep in-order response buffer; responses appear one cycle after accept.
// Optional misaligned-fetch check under IFETCH_MISALIGN_CHK_EN adds the resp_err port.
module inst_fetch_resp #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_addr,
`ifdef IFETCH_MISALIGN_CHK_EN
  output logic        resp_err,
`endif
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [1:0]    count;
  logic          wr_ptr, rd_ptr;
  logic [31:0]   buf_inst [2];
  logic [31:0]   buf_addr [2];
  logic          accept, consume;
  logic [AW-1:0] rd_idx, ld_idx;
  logic [31:0]   fetch_inst;

  assign rd_idx  = req_addr[AW+1:2];
  assign ld_idx  = ld_addr[AW+1:2];
  assign accept  = req_valid & req_ready;
  assign consume = resp_valid & resp_ready;

  // Upper address bits wrap away by design.
`ifdef IFETCH_MISALIGN_CHK_EN
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:AW+2], ld_addr[31:AW+2], ld_addr[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:AW+2], req_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};
`endif

  // Memory is never reset; loads work even while rst is high.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_idx] <= ld_data;
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  logic fetch_err;
  logic buf_err [2];

  always_comb begin
    fetch_err  = (req_addr[1:0] != 2'b00);
    fetch_inst = fetch_err ? 32'h0000_0013 : mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (accept) buf_err[wr_ptr] <= fetch_err;
  end

  assign resp_err = resp_valid & buf_err[rd_ptr];
`else
  always_comb begin
    fetch_inst = mem[rd_idx];
  end
`endif

  // Array read happens before the same-edge load lands, so same-cycle fetches see old data.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_inst[wr_ptr] <= fetch_inst;
      buf_addr[wr_ptr] <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept)  wr_ptr <= ~wr_ptr;
      if (consume) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, consume};
    end
  end

  assign req_ready  = ~rst & (count != 2'd2);
  assign resp_valid = (count != 2'd0);
  assign resp_inst  = resp_valid ? buf_inst[rd_ptr] : 32'd0;
  assign resp_addr  = resp_valid ? buf_addr[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp; directed vectors, monitor pops on each consumed response.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        resp_err;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  inst_fetch_resp #(.DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_addr(resp_addr),
`ifdef IFETCH_MISALIGN_CHK_EN
    .resp_err(resp_err),
`endif
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got inst %h addr %h, none expected", resp_inst, resp_addr);
      end else begin
        exp_t e;
        logic ok;
        e  = sb.pop_front();
        ok = (resp_inst === e.inst) && (resp_addr === e.addr);
`ifdef IFETCH_MISALIGN_CHK_EN
        ok = ok && (resp_err === e.err);
`endif
        if (!ok) begin
          fails++;
          $display("FAIL resp: got inst %h addr %h expected inst %h addr %h", resp_inst, resp_addr, e.inst, e.addr);
        end
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] inst, input logic err);
    int t = 0;
    exp_t e;
    req_valid = 1'b1; req_addr = a;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (req_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL issue_timeout: req_ready %b expected 1", req_ready);
    end else begin
      e.inst = inst; e.addr = a; e.err = err;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge clk); t++; end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    int c0;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;

    load(32'h0, 32'h11111111);
    load(32'h4, 32'h22222222);
    load(32'h8, 32'h33333333);
    @(negedge clk);
    check("ready_in_rst", req_ready, 0);
    check("valid_in_rst", resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);
    check("inst_idle_zero", resp_inst, 0);
    check("addr_idle_zero", resp_addr, 0);
    @(posedge clk); #1;

    // First-fetch latency: presented in the very next cycle.
    resp_ready = 1'b1;
    issue(32'h0, 32'h11111111, 1'b0);
    @(negedge clk);
    check("lat_valid", resp_valid, 1);
    check("lat_inst", resp_inst, 32'h11111111);
    @(posedge clk); #1;
    wait_drain();
    @(posedge clk); #1;

    // Back-to-back stream with one accept per cycle.
    c0 = cyc;
    issue(32'h0, 32'h11111111, 1'b0);
    issue(32'h4, 32'h22222222, 1'b0);
    issue(32'h8, 32'h33333333, 1'b0);
    check("b2b_cycles", cyc - c0, 3);
    wait_drain();

    // Backpressure: buffer fills, outputs hold, then drain in order.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue(32'h0, 32'h11111111, 1'b0);
    issue(32'h4, 32'h22222222, 1'b0);
    @(negedge clk);
    check("full_ready", req_ready, 0);
    check("hold_inst0", resp_inst, 32'h11111111);
    repeat (2) @(negedge clk);
    check("hold_inst2", resp_inst, 32'h11111111);
    check("hold_addr2", resp_addr, 0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_drain();

    // Same-cycle load and fetch of word 1 returns old data.
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = 32'h4; ld_data = 32'hAAAAAAAA;
    issue(32'h4, 32'h22222222, 1'b0);
    ld_we = 1'b0;
    issue(32'h4, 32'hAAAAAAAA, 1'b0);
    wait_drain();

    // Reset with two outstanding; load during reset must still land.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue(32'h0, 32'h11111111, 1'b0);
    issue(32'h4, 32'hAAAAAAAA, 1'b0);
    rst = 1'b1;
    ld_we = 1'b1; ld_addr = 32'hC; ld_data = 32'h44444444;
    @(negedge clk);
    check("ready_during_rst", req_ready, 0);
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b0; ld_we = 1'b0;
    @(negedge clk);
    check("post_rst_valid", resp_valid, 0);
    check("post_rst_inst", resp_inst, 0);
    check("post_rst_ready", req_ready, 1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(32'h0, 32'h11111111, 1'b0);
    issue(32'hC, 32'h44444444, 1'b0);
    // Address wrap: 0x400 aliases word 0 with DEPTH=256.
    issue(32'h400, 32'h11111111, 1'b0);
`ifdef IFETCH_MISALIGN_CHK_EN
    issue(32'h6, 32'h00000013, 1'b1);
`else
    issue(32'h6, 32'hAAAAAAAA, 1'b0);
`endif
    wait_drain();
    @(negedge clk);
    check("end_idle_valid", resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
